// File: rtl/commit_trace_fifo_if.sv
// Commit-trace bundle: one commit event in per cycle, serialised trace records and status out.
// master is the producing FIFO; slave is the consumer.
interface commit_trace_fifo_if #(
    parameter int CNT_W = 32
);
    logic             ev_valid;
    logic             ev_regwrite;
    logic [2:0]       ev_wreg;
    logic [15:0]      ev_wdata;
    logic             ev_memread;
    logic             ev_memwrite;
    logic [15:0]      ev_addr;
    logic [15:0]      ev_memdin;
    logic [15:0]      ev_memdout;
    logic             ev_halt;

    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_type;
    logic [2:0]       out_reg;
    logic [15:0]      out_addr;
    logic [15:0]      out_data;

    logic [CNT_W-1:0] inst_count;
    logic [CNT_W-1:0] drop_count;
    logic             overflow;
    logic             halted;

    modport master (
        input  ev_valid, ev_regwrite, ev_wreg, ev_wdata, ev_memread, ev_memwrite,
               ev_addr, ev_memdin, ev_memdout, ev_halt, out_ready,
        output out_valid, out_type, out_reg, out_addr, out_data,
               inst_count, drop_count, overflow, halted
    );

    modport slave (
        output ev_valid, ev_regwrite, ev_wreg, ev_wdata, ev_memread, ev_memwrite,
               ev_addr, ev_memdin, ev_memdout, ev_halt, out_ready,
        input  out_valid, out_type, out_reg, out_addr, out_data,
               inst_count, drop_count, overflow, halted
    );
endinterface

// File: rtl/commit_trace_fifo.sv
// Captures retiring commit events into a FIFO and serialises each entry into
// typed trace records (REG, LOAD, STORE, HALT) over a valid/ready handshake.
module commit_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    commit_trace_fifo_if.master bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // flags bit order doubles as record emission order: {halt, memwrite, memread, regwrite}
    typedef struct packed {
        logic [3:0]  flags;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        logic [15:0] addr;
        logic [15:0] memdin;
        logic [15:0] memdout;
    } entry_t;

    typedef enum logic [1:0] {
        T_REG   = 2'd0,
        T_LOAD  = 2'd1,
        T_STORE = 2'd2,
        T_HALT  = 2'd3
    } rec_t;

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } state_t;

    entry_t           mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    state_t           state_q, state_d;
    logic [3:0]       mask_q, mask_d;

    logic             out_valid_q, out_valid_d;
    rec_t             out_type_q, out_type_d;
    logic [2:0]       out_reg_q, out_reg_d;
    logic [15:0]      out_addr_q, out_addr_d;
    logic [15:0]      out_data_q, out_data_d;

    logic [CNT_W-1:0] inst_count_q, inst_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic             overflow_q, overflow_d;
    logic             halted_q, halted_d;

    entry_t           ev_ent;
    logic             active, push, drop, xfer, pop;
    logic [3:0]       rem;

    entry_t           sel_ent;
    logic [3:0]       sel_mask;
    logic             sel_vld;
    logic [AW-1:0]    head_idx;
    logic [AW:0]      head_cnt;

    function automatic rec_t first_rec(input logic [3:0] m);
        if (m[0]) return T_REG;
        else if (m[1]) return T_LOAD;
        else if (m[2]) return T_STORE;
        else return T_HALT;
    endfunction

    // Full check deliberately uses the registered count, so a same-cycle pop never frees a slot.
    always_comb begin : capture
        ev_ent.flags   = {bus.ev_halt, bus.ev_memwrite, bus.ev_memread, bus.ev_regwrite};
        ev_ent.wreg    = bus.ev_wreg;
        ev_ent.wdata   = bus.ev_wdata;
        ev_ent.addr    = bus.ev_addr;
        ev_ent.memdin  = bus.ev_memdin;
        ev_ent.memdout = bus.ev_memdout;

        active = bus.ev_valid && (state_q == RUN) && (ev_ent.flags != 4'b0);
        push   = active && (count_q != FULL_CNT);
        drop   = active && (count_q == FULL_CNT);

        xfer   = out_valid_q && bus.out_ready;
        rem    = mask_q & ~(4'b0001 << out_type_q);
        pop    = xfer && (rem == 4'b0);
    end

    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            RUN:     if (active && bus.ev_halt) state_d = STOP;
            STOP:    state_d = STOP;
            default: state_d = RUN;
        endcase
    end

    // Pick the entry feeding the next record; an empty FIFO forwards the incoming event directly.
    always_comb begin : head_select
        sel_vld  = 1'b0;
        sel_ent  = ev_ent;
        sel_mask = 4'b0;
        head_idx = rd_ptr_q;
        head_cnt = count_q;
        if (pop) begin
            head_idx = rd_ptr_q + AW'(1);
            head_cnt = count_q - (AW + 1)'(1);
        end
        if (xfer && (rem != 4'b0)) begin
            sel_vld  = 1'b1;
            sel_ent  = mem_q[rd_ptr_q];
            sel_mask = rem;
        end else if (head_cnt != '0) begin
            sel_vld  = 1'b1;
            sel_ent  = mem_q[head_idx];
            sel_mask = mem_q[head_idx].flags;
        end else if (push) begin
            sel_vld  = 1'b1;
            sel_ent  = ev_ent;
            sel_mask = ev_ent.flags;
        end
        if (halted_q) begin
            sel_vld  = 1'b0;
            sel_mask = 4'b0;
        end
    end

    always_comb begin : next_output
        out_valid_d = out_valid_q;
        out_type_d  = out_type_q;
        out_reg_d   = out_reg_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        mask_d      = mask_q;
        if (!out_valid_q || xfer) begin
            out_valid_d = sel_vld;
            mask_d      = sel_mask;
            out_type_d  = sel_vld ? first_rec(sel_mask) : T_REG;
            out_reg_d   = 3'b0;
            out_addr_d  = 16'h0;
            out_data_d  = 16'h0;
            if (sel_vld) begin
                case (out_type_d)
                    T_REG: begin
                        out_reg_d  = sel_ent.wreg;
                        out_data_d = sel_ent.wdata;
                    end
                    T_LOAD: begin
                        out_addr_d = sel_ent.addr;
                        out_data_d = sel_ent.memdout;
                    end
                    T_STORE: begin
                        out_addr_d = sel_ent.addr;
                        out_data_d = sel_ent.memdin;
                    end
                    default: begin
                        out_data_d = 16'h0;
                    end
                endcase
            end
        end
    end

    // Pure loads do not retire an instruction of their own, so they are left out of inst_count.
    always_comb begin : next_counters
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        inst_count_d = inst_count_q;
        if (active && (bus.ev_halt || bus.ev_regwrite || bus.ev_memwrite)) begin
            inst_count_d = inst_count_q + CNT_W'(1);
        end
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + CNT_W'(1);
        end
        overflow_d = overflow_q | drop;
        halted_d   = halted_q | (xfer && (out_type_q == T_HALT));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ev_ent;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mask_q       <= 4'b0;
            out_valid_q  <= 1'b0;
            out_type_q   <= T_REG;
            out_reg_q    <= 3'b0;
            out_addr_q   <= 16'h0;
            out_data_q   <= 16'h0;
            inst_count_q <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mask_q       <= mask_d;
            out_valid_q  <= out_valid_d;
            out_type_q   <= out_type_d;
            out_reg_q    <= out_reg_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            inst_count_q <= inst_count_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
            halted_q     <= halted_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_type   = out_type_q;
    assign bus.out_reg    = out_reg_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_data   = out_data_q;
    assign bus.inst_count = inst_count_q;
    assign bus.drop_count = drop_count_q;
    assign bus.overflow   = overflow_q;
    assign bus.halted     = halted_q;

endmodule

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
- In-DUT commit-event producer: the transmitting end of the per-cycle commit-trace interface that the processor bench samples.
- Captures each retiring cycle's register-write, load, store and halt activity into a FIFO.
- Serialises that activity into one typed trace record per handshake for a downstream consumer: a bench reader, log writer or hardware checker.
- Also maintains the retired-instruction counter and a sticky overflow indication.

Parameters:
- DEPTH, 8, number of captured commit entries; power of two, minimum 2.
- CNT_W, 32, width of inst_count and drop_count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ev_valid  in  1  commit event present this cycle.
- ev_regwrite  in  1  register file written.
- ev_wreg  in  3  destination register.
- ev_wdata  in  16  register write data.
- ev_memread  in  1  load performed.
- ev_memwrite  in  1  store performed.
- ev_addr  in  16  memory address.
- ev_memdin  in  16  store data.
- ev_memdout  in  16  load data.
- ev_halt  in  1  halt retired.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts record.
- out_type  out  2  record type: 0 REG, 1 LOAD, 2 STORE, 3 HALT.
- out_reg  out  3  register number; REG records only, else 0.
- out_addr  out  16  memory address; LOAD/STORE only, else 0.
- out_data  out  16  data: REG write data, LOAD read data, STORE write data; HALT 0.
- inst_count  out  CNT_W  retired instructions.
- drop_count  out  CNT_W  dropped events, saturating.
- overflow  out  1  sticky: at least one event dropped.
- halted  out  1  HALT record has been handed off.

Behaviour:
- Reset (rst low, asynchronous), all outputs 0:
  - FIFO empty; wr/rd pointers 0.
  - Head mask cleared; state RUN.
  - out_valid, out_type, out_reg, out_addr, out_data 0.
  - inst_count, drop_count, overflow, halted 0.
- Capture rule:
  - An event is "active" when ev_valid=1, state=RUN and at least one of regwrite, memread, memwrite, halt is 1.
  - Events with no flag set are ignored and not counted.
- Push:
  - Active event with count<DEPTH: the whole event (all flags and fields) is written at the rising edge.
  - The full check uses the registered count. There is no same-cycle bypass: a pop in the same cycle does not free a slot for that push.
- Overflow:
  - Active event with count==DEPTH is dropped.
  - overflow set to 1 (sticky until reset).
  - drop_count increments, saturating at all-ones.
- inst_count:
  - Increments by 1 per accepted or dropped active event with halt|regwrite|memwrite set.
  - Wraps modulo 2^CNT_W.
- Halt:
  - Once an event with ev_halt=1 is captured or dropped, state becomes STOP.
  - All later ev_* inputs are ignored.
- Serialisation (head entry):
  - Remaining-record mask = {halt, memwrite, memread, regwrite}, loaded when the entry reaches head.
  - Records emitted in fixed order REG, LOAD, STORE, HALT; one record per entry per set flag.
  - load+store in the same entry are both emitted, LOAD first.
- Output timing:
  - out_* are registered.
  - Earliest out_valid is the cycle after capture, i.e. one-cycle latency when empty.
- Handshake:
  - Record transfers on out_valid & out_ready at the rising edge.
  - While out_valid=1 and out_ready=0, all out_* hold stable.
  - out_valid never drops without a transfer, except on reset.
- Head advance:
  - Transfer of the entry's last record pops the entry.
  - The next head's first record is presented in the following cycle: back-to-back records with no bubble when out_ready is held high.
- halted:
  - Set the cycle after the HALT record transfers; remains 1.
  - out_valid is 0 thereafter.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Reset mid-operation: FIFO contents discarded, out_valid deasserted immediately (asynchronous).

Test Plan:
- Single REG event: wreg=3, wdata=0x1234, out_ready=1 → next cycle out_valid=1, type=0, reg=3, data=0x1234, addr=0; inst_count=1.
- Load with writeback: regwrite=1, wreg=5, wdata=0x00AA, memread=1, addr=0x0040, memdout=0x00AA, out_ready=1 → REG(5,0x00AA) then LOAD(0x0040,0x00AA) on consecutive cycles; inst_count=1.
- Backpressure: push STORE addr=0x0100, memdin=0xBEEF with out_ready=0 for 5 cycles → out_valid=1 and fields stable throughout; transfers on the cycle ready rises.
- Overflow, DEPTH=8, out_ready=0, 10 REG events → first 8 stored; overflow=1; drop_count=2; inst_count=10. Then ready=1 → exactly 8 records emitted in order.
- Halt: REG event, then halt event, then 3 further REG events → emits REG then HALT only; halted=1 the cycle after the HALT transfer; inst_count=2.
- Reset mid-stream: 4 queued entries, rst low for 1 cycle → out_valid=0 immediately; all counters 0; first post-reset event emitted normally.
